// File: rtl/gate_pair_tester.sv
// gate_pair_tester: exhaustive sweep and NAND response checker for 2-input gates.
// Optional GATE_PAIR_TESTER_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module gate_pair_tester #(
  parameter int WIDTH  = 2,
  parameter int SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   dut_out,
  output logic [WIDTH-1:0]   a_o,
  output logic [WIDTH-1:0]   b_o,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count,
  output logic [2*WIDTH-1:0] first_fail
);

  localparam int VW   = 2 * WIDTH;
  localparam int CW   = VW + 1;
  localparam int CNTW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    CHECK,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [VW-1:0]   v;
  logic [CNTW-1:0] cnt;
  logic            go;
  logic            settled;
  logic            miss;
  logic            last;
  logic            stop;

  assign a_o  = v[WIDTH-1:0];
  assign b_o  = v[VW-1:WIDTH];
  assign busy = (state == APPLY) || (state == CHECK);
  assign done = (state == DONE);
  assign pass = done && (err_count == '0);

  assign go      = start && ((state == IDLE) || (state == DONE));
  assign settled = (cnt == CNTW'(SETTLE - 1));
  assign last    = &v;
  assign miss    = (state == CHECK) &&
                   (dut_out != ~(a_o & b_o));

`ifdef GATE_PAIR_TESTER_STOP_ON_FAIL_EN
  assign stop = miss;
`else
  assign stop = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      (state == IDLE):  if (start) state_nx = APPLY;
      (state == APPLY): if (settled) state_nx = CHECK;
      (state == CHECK): state_nx = (last || stop) ? DONE : APPLY;
      (state == DONE):  if (start) state_nx = APPLY;
      default:          state_nx = IDLE;
    endcase
  end

  // Sweep datapath: vector index, settle counter and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v          <= '0;
      cnt        <= '0;
      err_count  <= '0;
      first_fail <= '0;
    end else if (go) begin
      v          <= '0;
      cnt        <= '0;
      err_count  <= '0;
      first_fail <= '0;
    end else begin
      if (state == APPLY) begin
        cnt <= settled ? '0 : cnt + CNTW'(1);
      end
      if (state == CHECK) begin
        if (miss) begin
          err_count <= err_count + CW'(1);
          if (err_count == '0) first_fail <= v;
        end
        if (!last && !stop) v <= v + VW'(1);
      end
    end
  end

endmodule

// File: tb/tb_gate_pair_tester.sv
// tb_gate_pair_tester: table-driven and randomized sweeps of gate_pair_tester.
// Covers SETTLE=1 and SETTLE=3 builds, reset mid-sweep and start while busy.
module tb_gate_pair_tester;

  localparam int K_NAND  = 0;
  localparam int K_STUCK = 1;
  localparam int K_AND   = 2;
  localparam int K_RAND  = 3;

  typedef struct {
    int kind;
    int sel;
    int exp_err;
    int exp_ff;
    int exp_pass;
    int exp_cyc;
    int exp_ab;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start_s;
  int         sel;
  logic [1:0] resp_tab [16];

  logic [1:0] a1, b1, o1, a3, b3, o3;
  logic       busy1, done1, pass1, busy3, done3, pass3;
  logic [4:0] ec1, ec3;
  logic [3:0] ff1, ff3;
  logic       st1, st3;

  assign st1 = start_s && (sel == 0);
  assign st3 = start_s && (sel == 1);
  assign o1  = resp_tab[{b1, a1}];
  assign o3  = resp_tab[{b3, a3}];

  gate_pair_tester #(.WIDTH(2), .SETTLE(1)) d1 (
    .clk(clk), .rst_n(rst_n), .start(st1), .dut_out(o1),
    .a_o(a1), .b_o(b1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(ec1), .first_fail(ff1)
  );

  gate_pair_tester #(.WIDTH(2), .SETTLE(3)) d3 (
    .clk(clk), .rst_n(rst_n), .start(st3), .dut_out(o3),
    .a_o(a3), .b_o(b3), .busy(busy3), .done(done3), .pass(pass3),
    .err_count(ec3), .first_fail(ff3)
  );

  logic [1:0] a_s, b_s;
  logic       busy_s, done_s, pass_s;
  logic [4:0] ec_s;
  logic [3:0] ff_s;

  always_comb begin
    a_s    = (sel == 1) ? a3 : a1;
    b_s    = (sel == 1) ? b3 : b1;
    busy_s = (sel == 1) ? busy3 : busy1;
    done_s = (sel == 1) ? done3 : done1;
    pass_s = (sel == 1) ? pass3 : pass1;
    ec_s   = (sel == 1) ? ec3 : ec1;
    ff_s   = (sel == 1) ? ff3 : ff1;
  end

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [1:0] nand_of(input int v);
    logic [3:0] vv;
    vv = v[3:0];
    return ~(vv[1:0] & vv[3:2]);
  endfunction

  task automatic fill(input int kind);
    for (int v = 0; v < 16; v++) begin
      logic [1:0] n;
      n = nand_of(v);
      case (kind)
        K_NAND:  resp_tab[v] = n;
        K_STUCK: resp_tab[v] = n & 2'b10;
        K_AND:   resp_tab[v] = ~n;
        default: resp_tab[v] = ($urandom_range(0, 3) == 0) ?
                   n ^ 2'($urandom_range(1, 3)) : n;
      endcase
    end
  endtask

  // Expected sweep outcome from the response table and the stop rule
  task automatic model(inout vec_t t);
    int s, endv;
    s = (t.sel == 1) ? 3 : 1;
    t.exp_err = 0;
    t.exp_ff  = 0;
    endv      = 15;
    for (int v = 0; v < 16; v++) begin
      if (resp_tab[v] != nand_of(v)) begin
        if (t.exp_err == 0) t.exp_ff = v;
        t.exp_err++;
`ifdef GATE_PAIR_TESTER_STOP_ON_FAIL_EN
        endv = v;
        break;
`endif
      end
    end
    t.exp_pass = (t.exp_err == 0) ? 1 : 0;
    t.exp_cyc  = (endv + 1) * (s + 1);
    t.exp_ab   = endv;
  endtask

  task automatic sweep(input vec_t t, input bit midpulse);
    int n, run, prev, bad_hold, bad_order, s;
    s = (t.sel == 1) ? 3 : 1;
    sel = t.sel;
    @(negedge clk);
    start_s = 1'b1;
    @(posedge clk);
    #1 start_s = 1'b0;
    chk("busy_at_start", busy_s, 1);
    chk("vec0_at_start", {b_s, a_s}, 0);
    n = 0; run = 1; prev = 0; bad_hold = 0; bad_order = 0;
    while (n < 400) begin
      @(posedge clk);
      #1;
      n++;
      if (midpulse && n == 7) start_s = 1'b1;
      if (midpulse && n == 8) start_s = 1'b0;
      if (done_s) begin
        if (run != s + 1) bad_hold++;
        break;
      end
      if (int'({b_s, a_s}) != prev) begin
        if (run != s + 1) bad_hold++;
        if (int'({b_s, a_s}) != prev + 1) bad_order++;
        prev = {b_s, a_s};
        run  = 1;
      end else begin
        run++;
      end
    end
    if (!done_s) begin
      chk("done_timeout", 0, 1);
      return;
    end
    chk("done_cycle", n, t.exp_cyc);
    chk("err_count", ec_s, t.exp_err);
    chk("first_fail", ff_s, t.exp_ff);
    chk("pass", pass_s, t.exp_pass);
    chk("final_ab", {b_s, a_s}, t.exp_ab);
    chk("busy_at_done", busy_s, 0);
    chk("hold_len", bad_hold, 0);
    chk("vec_order", bad_order, 0);
    @(negedge clk);
    chk("done_held", done_s, 1);
    chk("err_held", ec_s, t.exp_err);
  endtask

  vec_t tab [5];

  initial begin
    rst_n   = 1'b0;
    start_s = 1'b0;
    sel     = 0;
    fill(K_NAND);

`ifdef GATE_PAIR_TESTER_STOP_ON_FAIL_EN
    tab[0] = '{K_NAND,  0, 0,  0, 1, 32, 15};
    tab[1] = '{K_STUCK, 0, 1,  0, 0, 2,  0};
    tab[2] = '{K_AND,   0, 1,  0, 0, 2,  0};
    tab[3] = '{K_NAND,  1, 0,  0, 1, 64, 15};
    tab[4] = '{K_STUCK, 1, 1,  0, 0, 4,  0};
`else
    tab[0] = '{K_NAND,  0, 0,  0, 1, 32, 15};
    tab[1] = '{K_STUCK, 0, 12, 0, 0, 32, 15};
    tab[2] = '{K_AND,   0, 16, 0, 0, 32, 15};
    tab[3] = '{K_NAND,  1, 0,  0, 1, 64, 15};
    tab[4] = '{K_STUCK, 1, 12, 0, 0, 64, 15};
`endif

    repeat (2) @(negedge clk);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_pass", pass1, 0);
    chk("rst_err", ec1, 0);
    chk("rst_ab", {b1, a1}, 0);
    chk("rst_busy3", busy3, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_no_start", busy1, 0);

    for (int i = 0; i < 5; i++) begin
      fill(tab[i].kind);
      sweep(tab[i], 1'b0);
    end

    for (int i = 0; i < 6; i++) begin
      vec_t t;
      t.kind = K_RAND;
      t.sel  = $urandom_range(0, 1);
      fill(K_RAND);
      model(t);
      sweep(t, 1'b0);
    end

    // Reset mid-sweep, then restart with a start pulse while busy
    fill(K_NAND);
    sel = 0;
    @(negedge clk);
    start_s = 1'b1;
    @(posedge clk);
    #1 start_s = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy1, 0);
    chk("midrst_done", done1, 0);
    chk("midrst_pass", pass1, 0);
    chk("midrst_err", ec1, 0);
    chk("midrst_ff", ff1, 0);
    chk("midrst_ab", {b1, a1}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("post_rst_idle", busy1, 0);
    sweep(tab[0], 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/gate_pair_tester.md
# gate_pair_tester

Self-checking exhaustive stimulus generator and response checker for the team's 2-bit two-input gate blocks, such as the bitwise NAND. It drives every combination of the `a`/`b` operand buses into the device under test and samples the DUT output after a programmable settle time. It compares each sample against the expected bitwise NAND and reports a pass/fail verdict, an error count and the first failing vector. It sits on the lab board beside the gate under test and is started by a push-button pulse.

## Interface
- `WIDTH`, 2: operand width of the DUT; vector space is 2^(2·WIDTH).
- `SETTLE`, 1: cycles each vector is held before sampling; legal range ≥1.

- `clk` input 1: single clock, rising-edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: single-cycle request to begin a sweep; ignored while `busy`.
- `dut_out` input WIDTH: DUT response, e.g. the NAND `out` bus.
- `a_o` output WIDTH: operand A driven to the DUT.
- `b_o` output WIDTH: operand B driven to the DUT.
- `busy` output 1: sweep in progress.
- `done` output 1: level; a sweep has completed and results are valid.
- `pass` output 1: `done` and zero errors.
- `err_count` output 2·WIDTH+1: number of mismatching vectors in the last sweep.
- `first_fail` output 2·WIDTH: index of the first mismatching vector; 0 when none.

## Operation
- Vector index `v` (2·WIDTH bits): `a_o = v[WIDTH-1:0]`, `b_o = v[2·WIDTH-1:WIDTH]`; the index counts 0 to 2^(2·WIDTH)−1 without wrap.
- Expected response: `~(a_o & b_o)`, bitwise. A vector mismatches if any bit differs.
- FSM states:
  - IDLE: `busy`=0, `done`=0. On `start`=1, go to APPLY.
  - APPLY: operands held stable; settle counter runs SETTLE cycles, then go to CHECK.
  - CHECK: one cycle; operands still stable; `dut_out` is compared at the closing edge.
    - Mismatch: increment `err_count`. If it is the first mismatch of the sweep, capture `first_fail`=v.
    - If v is the last vector, go to DONE. Otherwise v+1 and return to APPLY.
  - DONE: `busy`=0, `done`=1; results and last operands held. On `start`=1, behave as in IDLE.
- Sweep start (IDLE or DONE accepting `start`): clear `err_count`, `first_fail`, `done` and v; drive vector 0.
- `start` while `busy` has no effect. `start` held high in DONE restarts the sweep every time DONE is re-entered.
- `pass` is combinational: `done && err_count==0`.
- `dut_out` is sampled only in CHECK. It is assumed synchronous to `clk`; the settle time covers DUT propagation.

## Timing
- Reset (asynchronous, any state, including mid-sweep): state IDLE; `a_o`=0, `b_o`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_fail`=0. After release, a new `start` is required.
- `start` is sampled at edge k. `busy` and vector 0 are visible after edge k.
- Each vector occupies SETTLE+1 cycles.
- `done` rises after edge k + 2^(2·WIDTH)·(SETTLE+1). With defaults this is edge k+32. `busy` falls on the same edge.
- `err_count`, `first_fail` and `pass` are stable whenever `done`=1.

## Configuration
- `GATE_PAIR_TESTER_STOP_ON_FAIL_EN`
  - Defined: the first mismatch ends the sweep at that CHECK edge and moves to DONE. `err_count`=1, and `first_fail`, `a_o` and `b_o` hold the failing vector.
  - Undefined: the full sweep always runs and every mismatch is counted.

## Test plan
- Correct NAND DUT, defaults, `start` pulse at edge k: `done`=1 at edge k+32, `pass`=1, `err_count`=0, `first_fail`=0, `a_o`=`b_o`=2'b11 at end.
- DUT `out[0]` stuck at 0, full sweep: `err_count`=12, `first_fail`=0, `pass`=0.
- AND gate substituted for NAND: `err_count`=16, `first_fail`=0, `pass`=0.
- Stuck-at-0 DUT with `GATE_PAIR_TESTER_STOP_ON_FAIL_EN`: `done` at edge k+2, `err_count`=1, `first_fail`=0, `a_o`=`b_o`=0.
- `rst_n` pulled low at edge k+10 mid-sweep: all outputs 0 immediately. A `start` re-pulsed 3 cycles after release gives a clean pass 32 cycles later. A `start` pulsed during `busy` changes nothing.
- SETTLE=3 with a correct DUT: `done` at edge k+64, each operand pair held exactly 4 cycles, `pass`=1.
